// File: rtl/shifter_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : shifter_pkg
// Description : Shared types and helpers for the pipelined barrel shifter.
//               Holds the operation encoding and small op classifiers.
// Revision    : 1.0 - initial release
// ============================================================================
package shifter_pkg;

    localparam int SHIFT_OP_W = 3;

    typedef enum logic [SHIFT_OP_W-1:0] {
        OP_SLL  = 3'd0,
        OP_SRL  = 3'd1,
        OP_SRA  = 3'd2,
        OP_ROL  = 3'd3,
        OP_ROR  = 3'd4,
        OP_SLLW = 3'd5,
        OP_SRLW = 3'd6,
        OP_SRAW = 3'd7
    } shift_op_e;

    // Word ops work on the low 32 bits and sign-extend the result on DW=64.
    function automatic logic is_w_op(input shift_op_e op);
        return (op == OP_SLLW) || (op == OP_SRLW) || (op == OP_SRAW);
    endfunction

    function automatic logic is_left_op(input shift_op_e op);
        return (op == OP_SLL) || (op == OP_ROL) || (op == OP_SLLW);
    endfunction

endpackage
`default_nettype wire

// File: rtl/shifter_pipe_if.sv
`default_nettype none
// ============================================================================
// Module      : shifter_pipe_if
// Description : Operand/result handshake bundle for shifter_pipe.
//               slave  : the shifter (consumes operands, produces results)
//               master : the issue/writeback side driving it
//               Signals: flush_i, valid_i/ready_o, op_i, data0_i, data1_i,
//               tag_i (operand side); valid_o/ready_i, result_o, tag_o
//               (result side).
// Revision    : 1.0 - initial release
// ============================================================================
interface shifter_pipe_if
    import shifter_pkg::*;
#(
    parameter int DW    = 32,
    parameter int TAG_W = 5
) ();

    logic                  flush_i;
    logic                  valid_i;
    logic                  ready_o;
    logic [SHIFT_OP_W-1:0] op_i;
    logic [DW-1:0]         data0_i;
    logic [DW-1:0]         data1_i;
    logic [TAG_W-1:0]      tag_i;
    logic                  valid_o;
    logic                  ready_i;
    logic [DW-1:0]         result_o;
    logic [TAG_W-1:0]      tag_o;

    modport master (
        output flush_i, valid_i, op_i, data0_i, data1_i, tag_i, ready_i,
        input  ready_o, valid_o, result_o, tag_o
    );

    modport slave (
        input  flush_i, valid_i, op_i, data0_i, data1_i, tag_i, ready_i,
        output ready_o, valid_o, result_o, tag_o
    );

endinterface
`default_nettype wire

// File: rtl/shifter_pipe_stage.sv
`default_nettype none
// ============================================================================
// Module      : shifter_stage
// Description : One pipeline stage of the barrel shifter. Applies shift
//               levels LVL_LO..LVL_HI (shift by 2^k when amt[k] is set),
//               then registers valid/op/amount/data/tag.
//               Ports: clk_i, rst_i, flush; upstream valid/op/amt/data/tag
//               with ready back; next_ready from downstream; q_* outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module shifter_stage
    import shifter_pkg::*;
#(
    parameter int DW     = 32,
    parameter int SW     = $clog2(DW),
    parameter int TAG_W  = 5,
    parameter int LVL_LO = 0,
    parameter int LVL_HI = 0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush,
    input  logic             valid,
    input  shift_op_e        op,
    input  logic [SW-1:0]    amt,
    input  logic [DW-1:0]    data,
    input  logic [TAG_W-1:0] tag,
    output logic             ready,
    input  logic             next_ready,
    output logic             q_valid,
    output shift_op_e        q_op,
    output logic [SW-1:0]    q_amt,
    output logic [DW-1:0]    q_data,
    output logic [TAG_W-1:0] q_tag
);

    logic             r_valid;
    shift_op_e        r_op;
    logic [SW-1:0]    r_amt;
    logic [DW-1:0]    r_data;
    logic [TAG_W-1:0] r_tag;
    logic [DW-1:0]    w_shifted;

    // Levels compose in any order; rotates compose because each level
    // is itself a full-width rotate. An empty level range (LVL_LO > LVL_HI)
    // leaves the stage as a pure register.
    always_comb begin
        w_shifted = data;
        for (int k = LVL_LO; k <= LVL_HI; k++) begin
            if (amt[k]) begin
                case (op)
                    OP_SLL, OP_SLLW: w_shifted = w_shifted << (1 << k);
                    OP_SRL, OP_SRLW: w_shifted = w_shifted >> (1 << k);
                    OP_SRA, OP_SRAW: w_shifted = DW'($signed(w_shifted) >>> (1 << k));
                    OP_ROL: w_shifted = (w_shifted << (1 << k)) | (w_shifted >> (DW - (1 << k)));
                    OP_ROR: w_shifted = (w_shifted >> (1 << k)) | (w_shifted << (DW - (1 << k)));
                    default: w_shifted = w_shifted;
                endcase
            end
        end
    end

    // Loadable when empty or when the content moves on this edge.
    assign ready = !r_valid || next_ready;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_valid <= 1'b0;
            r_op    <= OP_SLL;
            r_amt   <= '0;
            r_data  <= '0;
            r_tag   <= '0;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (ready) begin
            r_valid <= valid;
            if (valid) begin
                r_op   <= op;
                r_amt  <= amt;
                r_data <= w_shifted;
                r_tag  <= tag;
            end
        end
    end

    assign q_valid = r_valid;
    assign q_op    = r_op;
    assign q_amt   = r_amt;
    assign q_data  = r_data;
    assign q_tag   = r_tag;

endmodule
`default_nettype wire

// File: rtl/shifter_pipe.sv
`default_nettype none
// ============================================================================
// Module      : shifter_pipe
// Description : Pipelined barrel shifter (SLL/SRL/SRA/ROL/ROR + W variants)
//               with valid/ready handshakes and synchronous flush.
//               Ports: clk_i, rst_i (sync, active-high), bus (slave view of
//               shifter_pipe_if carrying operands, results and handshakes).
// Revision    : 1.0 - initial release
// ============================================================================
module shifter_pipe
    import shifter_pkg::*;
#(
    parameter int DW          = 32,
    parameter int SHIFT_WIDTH = $clog2(DW),
    parameter int STAGES      = 2,
    parameter int TAG_W       = 5
) (
    input  logic          clk_i,
    input  logic          rst_i,
    shifter_pipe_if.slave bus
);

    localparam int c_LVL_PER = (SHIFT_WIDTH + STAGES - 1) / STAGES;

    // Index 0 is the prepared input; index s+1 is the output of stage s.
    logic                   w_valid [STAGES+1];
    shift_op_e              w_op    [STAGES+1];
    logic [SHIFT_WIDTH-1:0] w_amt   [STAGES+1];
    logic [DW-1:0]          w_data  [STAGES+1];
    logic [TAG_W-1:0]       w_tag   [STAGES+1];
    logic                   w_rdy   [STAGES+1];

    logic [DW-1:0]          w_data0;
    logic [SHIFT_WIDTH-1:0] w_amt0;
    logic                   w_unused;

    assign w_valid[0]    = bus.valid_i;
    assign w_op[0]       = shift_op_e'(bus.op_i);
    assign w_amt[0]      = w_amt0;
    assign w_data[0]     = w_data0;
    assign w_tag[0]      = bus.tag_i;
    assign w_rdy[STAGES] = bus.ready_i;

    assign bus.ready_o = w_rdy[0];
    assign bus.valid_o = w_valid[STAGES];
    assign bus.tag_o   = w_tag[STAGES];

    if (DW == 64) begin : g_w64
        // Word ops: the low word is placed in a 64-bit lane with the fill
        // the right shift needs (sign for SRAW, zero otherwise), so the low
        // 32 bits of the 64-bit shift equal the 32-bit result.
        always_comb begin
            w_data0 = bus.data0_i;
            w_amt0  = bus.data1_i[SHIFT_WIDTH-1:0];
            if (is_w_op(w_op[0])) begin
                w_amt0      = '0;
                w_amt0[4:0] = bus.data1_i[4:0];
                w_data0     = {{32{(w_op[0] == OP_SRAW) & bus.data0_i[31]}},
                               bus.data0_i[31:0]};
            end
        end

        assign bus.result_o = is_w_op(w_op[STAGES])
                            ? {{32{w_data[STAGES][31]}}, w_data[STAGES][31:0]}
                            : w_data[STAGES];
    end else begin : g_w32
        // At 32 bits the W ops are plain SLL/SRL/SRA with the same amount.
        assign w_data0      = bus.data0_i;
        assign w_amt0       = bus.data1_i[SHIFT_WIDTH-1:0];
        assign bus.result_o = w_data[STAGES];
    end

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        localparam int c_LO  = s * c_LVL_PER;
        localparam int c_END = ((s + 1) * c_LVL_PER < SHIFT_WIDTH) ? (s + 1) * c_LVL_PER
                                                                  : SHIFT_WIDTH;

        shifter_stage #(
            .DW     (DW),
            .SW     (SHIFT_WIDTH),
            .TAG_W  (TAG_W),
            .LVL_LO (c_LO),
            .LVL_HI (c_END - 1)
        ) u_stage (
            .clk_i      (clk_i),
            .rst_i      (rst_i),
            .flush      (bus.flush_i),
            .valid      (w_valid[s]),
            .op         (w_op[s]),
            .amt        (w_amt[s]),
            .data       (w_data[s]),
            .tag        (w_tag[s]),
            .ready      (w_rdy[s]),
            .next_ready (w_rdy[s+1]),
            .q_valid    (w_valid[s+1]),
            .q_op       (w_op[s+1]),
            .q_amt      (w_amt[s+1]),
            .q_data     (w_data[s+1]),
            .q_tag      (w_tag[s+1])
        );
    end

    // Upper amount bits and the spent amount of the last stage are dropped.
    assign w_unused = ^{bus.data1_i, w_amt[STAGES], w_op[STAGES]};

endmodule
`default_nettype wire

// File: tb/tb_shifter_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_shifter_pipe
// Description : Directed self-checking bench. A DW=32/STAGES=2 instance
//               covers latency, ops, streaming, backpressure, flush and
//               reset; six DW=64 instances (STAGES=1..6) share vectors to
//               check results and latency in each configuration.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_shifter_pipe;
    import shifter_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // ---------------- DW=32, STAGES=2 instance ----------------
    shifter_pipe_if #(.DW(32), .TAG_W(5)) a_if ();

    shifter_pipe #(.DW(32), .SHIFT_WIDTH(5), .STAGES(2), .TAG_W(5)) u_dut_a (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (a_if.slave)
    );

    typedef struct packed {
        logic [31:0] res;
        logic [4:0]  tag;
    } exp_t;

    exp_t q[$];
    logic        hold_prev = 1'b0;
    logic [31:0] prev_res  = '0;
    logic [4:0]  prev_tag  = '0;
    int          n_out     = 0;

    // Result monitor: in-order scoreboard plus stability under backpressure.
    always @(negedge clk) begin
        if (!rst && a_if.valid_o) begin
            if (hold_prev) begin
                check("hold_result", 64'(a_if.result_o), 64'(prev_res));
                check("hold_tag", 64'(a_if.tag_o), 64'(prev_tag));
            end
            if (a_if.ready_i) begin
                if (q.size() == 0) begin
                    check("spurious_valid", 64'(a_if.valid_o), 64'd0);
                end else begin
                    check("a_result", 64'(a_if.result_o), 64'(q[0].res));
                    check("a_tag", 64'(a_if.tag_o), 64'(q[0].tag));
                    void'(q.pop_front());
                end
                n_out <= n_out + 1;
            end
        end
        hold_prev <= !rst && a_if.valid_o && !a_if.ready_i;
        prev_res  <= a_if.result_o;
        prev_tag  <= a_if.tag_o;
    end

    // Called at posedge+1; returns at posedge+1 just after the accepting edge.
    task automatic send(input logic [2:0] op, input logic [31:0] d0, input logic [31:0] d1,
                        input logic [4:0] tag, input logic [31:0] exp);
        logic acc;
        int   n;
        acc = 1'b0;
        n   = 0;
        a_if.op_i    = op;
        a_if.data0_i = d0;
        a_if.data1_i = d1;
        a_if.tag_i   = tag;
        a_if.valid_i = 1'b1;
        while (!acc && n < 50) begin
            @(negedge clk);
            acc = a_if.ready_o;
            if (acc) q.push_back('{res: exp, tag: tag});
            @(posedge clk);
            #1;
            n++;
        end
        if (!acc) check("send_timeout", 64'd0, 64'd1);
        a_if.valid_i = 1'b0;
    endtask

    // ---------------- DW=64 sweep, STAGES=1..6 ----------------
    logic        b_valid_i;
    logic [2:0]  b_op;
    logic [63:0] b_d0, b_d1;
    logic [4:0]  b_tag;
    logic        b_valid_o [1:6];
    logic [63:0] b_res     [1:6];
    logic [4:0]  b_tag_o   [1:6];

    for (genvar s = 1; s <= 6; s++) begin : g_sweep
        shifter_pipe_if #(.DW(64), .TAG_W(5)) b_if ();
        assign b_if.flush_i = 1'b0;
        assign b_if.ready_i = 1'b1;
        assign b_if.valid_i = b_valid_i;
        assign b_if.op_i    = b_op;
        assign b_if.data0_i = b_d0;
        assign b_if.data1_i = b_d1;
        assign b_if.tag_i   = b_tag;
        assign b_valid_o[s] = b_if.valid_o;
        assign b_res[s]     = b_if.result_o;
        assign b_tag_o[s]   = b_if.tag_o;

        shifter_pipe #(.DW(64), .SHIFT_WIDTH(6), .STAGES(s), .TAG_W(5)) u_dut_b (
            .clk_i (clk),
            .rst_i (rst),
            .bus   (b_if.slave)
        );
    end

    typedef struct {
        logic [2:0]  op;
        logic [63:0] d0;
        logic [63:0] d1;
        logic [63:0] exp;
    } vec_t;

    vec_t vecs [9];

    initial begin
        vecs = '{
            '{OP_SRAW, 64'h0000_0000_8000_0000, 64'h21, 64'hFFFF_FFFF_C000_0000},
            '{OP_SLLW, 64'h0000_0000_0000_0001, 64'd31, 64'hFFFF_FFFF_8000_0000},
            '{OP_SLL,  64'h0000_0000_0000_0001, 64'd63, 64'h8000_0000_0000_0000},
            '{OP_SRA,  64'h8000_0000_0000_0000, 64'h44, 64'hF800_0000_0000_0000},
            '{OP_ROR,  64'h0000_0000_0000_0001, 64'd1,  64'h8000_0000_0000_0000},
            '{OP_ROL,  64'h8000_0000_0000_0001, 64'd4,  64'h0000_0000_0000_0018},
            '{OP_SRLW, 64'hFFFF_FFFF_8000_0000, 64'd31, 64'h0000_0000_0000_0001},
            '{OP_SLLW, 64'h0000_0000_8000_1234, 64'd0,  64'hFFFF_FFFF_8000_1234},
            '{OP_SRAW, 64'hABCD_0000_4000_0000, 64'h3E, 64'h0000_0000_0000_0001}
        };

        rst          = 1'b1;
        a_if.flush_i = 1'b0;
        a_if.valid_i = 1'b0;
        a_if.op_i    = '0;
        a_if.data0_i = '0;
        a_if.data1_i = '0;
        a_if.tag_i   = '0;
        a_if.ready_i = 1'b1;
        b_valid_i    = 1'b0;
        b_op         = '0;
        b_d0         = '0;
        b_d1         = '0;
        b_tag        = '0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_valid_o", 64'(a_if.valid_o), 64'd0);
        check("reset_result_o", 64'(a_if.result_o), 64'd0);
        check("reset_tag_o", 64'(a_if.tag_o), 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("ready_after_reset", 64'(a_if.ready_o), 64'd1);
        @(posedge clk);
        #1;

        // Latency: valid_o two cycles after acceptance
        send(OP_SRA, 32'h8000_00F0, 32'd4, 5'd1, 32'hF800_000F);
        @(negedge clk);
        check("lat_cycle1_valid", 64'(a_if.valid_o), 64'd0);
        @(negedge clk);
        check("lat_cycle2_valid", 64'(a_if.valid_o), 64'd1);
        check("lat_result", 64'(a_if.result_o), 64'hF800_000F);
        @(posedge clk);
        #1;

        // Directed ops on DW=32 (W ops behave as plain shifts)
        send(OP_ROR,  32'h0000_0001, 32'd1,  5'd2, 32'h8000_0000);
        send(OP_ROL,  32'h8000_0001, 32'd36, 5'd3, 32'h0000_0018);
        send(OP_SRLW, 32'h8000_0000, 32'd31, 5'd4, 32'h0000_0001);
        send(OP_SLL,  32'h0000_0001, 32'd35, 5'd5, 32'h0000_0008);
        send(OP_SRAW, 32'h8000_0000, 32'h3F, 5'd6, 32'hFFFF_FFFF);
        send(OP_SRL,  32'hF0F0_0000, 32'd0,  5'd7, 32'hF0F0_0000);

        // Back-to-back stream, tags 0..7
        for (int i = 0; i < 8; i++)
            send(OP_SLL, 32'd1, 32'(i), 5'(i), 32'd1 << i);

        // Backpressure: pipe is full, ready_o must drop and outputs hold
        a_if.ready_i = 1'b0;
        a_if.op_i    = OP_SRL;
        a_if.data0_i = 32'h0000_0100;
        a_if.data1_i = 32'd4;
        a_if.tag_i   = 5'd8;
        a_if.valid_i = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("stall_ready_o", 64'(a_if.ready_o), 64'd0);
            check("stall_valid_o", 64'(a_if.valid_o), 64'd1);
            @(posedge clk);
            #1;
        end
        a_if.ready_i = 1'b1;
        send(OP_SRL, 32'h0000_0100, 32'd4, 5'd8, 32'h0000_0010);
        for (int c = 0; c < 20 && q.size() != 0; c++) @(negedge clk);
        @(negedge clk);
        check("drain_queue", 64'(q.size()), 64'd0);
        check("out_count", 64'(n_out), 64'd16);

        // Flush with a concurrent input while full and stalled
        @(posedge clk);
        #1 a_if.ready_i = 1'b0;
        send(OP_SLL, 32'd3, 32'd1, 5'd9,  32'd6);
        send(OP_SLL, 32'd3, 32'd2, 5'd10, 32'd12);
        q.delete();
        a_if.flush_i = 1'b1;
        a_if.op_i    = OP_SLL;
        a_if.data0_i = 32'd5;
        a_if.data1_i = 32'd1;
        a_if.tag_i   = 5'd11;
        a_if.valid_i = 1'b1;
        @(posedge clk);
        #1;
        a_if.flush_i = 1'b0;
        a_if.valid_i = 1'b0;
        @(negedge clk);
        check("flush_valid_o", 64'(a_if.valid_o), 64'd0);
        check("flush_ready_o", 64'(a_if.ready_o), 64'd1);
        @(posedge clk);
        #1 a_if.ready_i = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("post_flush_valid", 64'(a_if.valid_o), 64'd0);
        end

        // Same case with reset: result_o and tag_o also clear
        @(posedge clk);
        #1 a_if.ready_i = 1'b0;
        send(OP_SLL, 32'd3, 32'd4, 5'd12, 32'd48);
        send(OP_SLL, 32'd3, 32'd5, 5'd13, 32'd96);
        q.delete();
        rst          = 1'b1;
        a_if.tag_i   = 5'd14;
        a_if.valid_i = 1'b1;
        @(posedge clk);
        #1;
        rst          = 1'b0;
        a_if.valid_i = 1'b0;
        @(negedge clk);
        check("rst_valid_o", 64'(a_if.valid_o), 64'd0);
        check("rst_result_o", 64'(a_if.result_o), 64'd0);
        check("rst_tag_o", 64'(a_if.tag_o), 64'd0);
        check("rst_ready_o", 64'(a_if.ready_o), 64'd1);
        @(posedge clk);
        #1 a_if.ready_i = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("post_rst_valid", 64'(a_if.valid_o), 64'd0);
        end

        // DW=64 sweep: result and latency == STAGES for every instance
        @(posedge clk);
        #1;
        for (int v = 0; v < 9; v++) begin
            b_op      = vecs[v].op;
            b_d0      = vecs[v].d0;
            b_d1      = vecs[v].d1;
            b_tag     = 5'(v);
            b_valid_i = 1'b1;
            @(posedge clk);
            #1 b_valid_i = 1'b0;
            for (int c = 1; c <= 6; c++) begin
                @(negedge clk);
                for (int s = 1; s <= 6; s++) begin
                    check($sformatf("sw%0d_v%0d_c%0d_valid", s, v, c),
                          64'(b_valid_o[s]), 64'(c == s));
                    if (c == s) begin
                        check($sformatf("sw%0d_v%0d_result", s, v), b_res[s], vecs[v].exp);
                        check($sformatf("sw%0d_v%0d_tag", s, v), 64'(b_tag_o[s]), 64'(v));
                    end
                end
            end
            @(posedge clk);
            #1;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
